// File: rtl/crc_24_ble_pkg.sv
// ---------------------------------------------------------------------------
// crc_24_ble_pkg
// Shared constants for the BLE 24-bit CRC sequencer:
//   CRC_W        - CRC register width
//   BLE_POLY     - Galois feedback taps of x^24+x^10+x^9+x^6+x^4+x^3+x+1
//                  (the x^24 term is implicit)
//   BLE_ADV_INIT - CRC seed used on advertising channels
//   ST_*         - controller state encoding
// ---------------------------------------------------------------------------
package crc_24_ble_pkg;

  localparam int          CRC_W        = 24;
  localparam logic [23:0] BLE_POLY     = 24'h00065B;
  localparam logic [23:0] BLE_ADV_INIT = 24'h555555;

  // Controller states. They are kept as plain constants so that older
  // tools and netlist readers see a fixed 2-bit encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage : crc_24_ble_pkg

// File: rtl/crc_24_ble_ctrl_if.sv
// ---------------------------------------------------------------------------
// crc_24_ble_ctrl_if
// Byte stream from the link-layer packet buffer into the CRC sequencer.
//   s_data  - packet byte
//   s_valid - byte valid
//   s_last  - final byte of the packet (meaningful only at handshake)
//   s_ready - sink can take a byte; transfer when s_valid && s_ready
// Modports: master = packet buffer side, slave = CRC sequencer side.
// ---------------------------------------------------------------------------
interface crc_24_ble_ctrl_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface : crc_24_ble_ctrl_if

// File: rtl/crc_24_ble_lfsr.sv
// ---------------------------------------------------------------------------
// crc_24_ble_lfsr
// Bit-serial Galois LFSR, one data bit per enabled clock.
//   clk_i   - clock, rising edge
//   rst_n_i - synchronous active-low reset, clears the register
//   load_i  - load init_i into the register (wins over en_i)
//   init_i  - seed value
//   en_i    - advance one step using data_i
//   data_i  - input data bit
//   crc_o   - current register contents
// Step: fb = crc[MSB] ^ d; crc <= {crc[MSB-1:0],0} ^ (fb ? POLY : 0)
// ---------------------------------------------------------------------------
module crc_24_ble_lfsr #(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] POLY  = 24'h00065B
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] init_i,
  input  logic             en_i,
  input  logic             data_i,
  output logic [WIDTH-1:0] crc_o
);

  logic [WIDTH-1:0] crc_reg;
  logic [WIDTH-1:0] crc_next;
  logic             fb;

  assign fb = crc_reg[WIDTH-1] ^ data_i;

  // Bit 0 receives only the feedback tap; every other bit is the shifted
  // neighbour, XORed with feedback where the polynomial has a tap.
  assign crc_next[0] = fb & POLY[0];

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_step
      assign crc_next[gi] = crc_reg[gi-1] ^ (fb & POLY[gi]);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      crc_reg <= '0;
    end else if (load_i) begin
      crc_reg <= init_i;
    end else if (en_i) begin
      crc_reg <= crc_next;
    end
  end

  assign crc_o = crc_reg;

endmodule : crc_24_ble_lfsr

// File: rtl/crc_24_ble_ctrl.sv
// ---------------------------------------------------------------------------
// crc_24_ble_ctrl
// Byte-level sequencer around a bit-serial BLE CRC LFSR. Accepts a packet as
// a byte stream, seeds the LFSR per packet, shifts each byte LSB-first (one
// bit per clock, 9 cycles per byte) and reports the CRC plus a compare
// against an expected value.
//   clk_i      - clock, rising edge
//   rst_n_i    - synchronous active-low reset
//   start_i    - begin packet (IDLE only)
//   init_i     - LFSR seed, sampled with start_i
//   exp_crc_i  - expected CRC, sampled with start_i
//   abort_i    - abandon packet, back to IDLE, no done_o
//   s_bus      - byte stream (slave side)
//   busy_o     - high outside IDLE
//   done_o     - one-cycle pulse, CRC final
//   crc_o      - LFSR contents
//   crc_ok_o   - crc_o matched the expected CRC, valid with done_o
//   byte_cnt_o - bytes accepted in the current packet (wraps)
// ---------------------------------------------------------------------------
module crc_24_ble_ctrl
  import crc_24_ble_pkg::*;
#(
  parameter int               WIDTH = CRC_W,
  parameter logic [WIDTH-1:0] POLY  = BLE_POLY,
  parameter int               CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     init_i,
  input  logic [WIDTH-1:0]     exp_crc_i,
  input  logic                 abort_i,
  crc_24_ble_ctrl_if.slave     s_bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIDTH-1:0]     crc_o,
  output logic                 crc_ok_o,
  output logic [CNT_W-1:0]     byte_cnt_o
);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [7:0]       byte_reg;
  logic             last_reg;
  logic [2:0]       bit_idx_reg;
  logic [CNT_W-1:0] byte_cnt_reg;
  logic [WIDTH-1:0] exp_reg;
  logic             ok_reg;

  logic             lfsr_load;
  logic             lfsr_en;
  logic             handshake;
  logic [WIDTH-1:0] crc;

  // Abort beats the handshake, so a byte presented in the abort cycle is
  // not consumed even though s_ready is up.
  assign handshake = (state_reg == ST_ACCEPT) && s_bus.s_valid && !abort_i;

  always_comb begin
    state_next = state_reg;
    lfsr_load  = 1'b0;
    lfsr_en    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_next = ST_ACCEPT;
          lfsr_load  = 1'b1;
        end
      end
      ST_ACCEPT: begin
        if (abort_i) begin
          state_next = ST_IDLE;
        end else if (s_bus.s_valid) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort_i) begin
          state_next = ST_IDLE;
        end else begin
          lfsr_en = 1'b1;
          if (bit_idx_reg == 3'd7) begin
            state_next = last_reg ? ST_DONE : ST_ACCEPT;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg    <= ST_IDLE;
      byte_reg     <= '0;
      last_reg     <= 1'b0;
      bit_idx_reg  <= '0;
      byte_cnt_reg <= '0;
      exp_reg      <= '0;
      ok_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_reg == ST_IDLE && start_i && !abort_i) begin
        exp_reg      <= exp_crc_i;
        byte_cnt_reg <= '0;
        ok_reg       <= 1'b0;
      end

      if (handshake) begin
        byte_reg     <= s_bus.s_data;
        last_reg     <= s_bus.s_last;
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
        bit_idx_reg  <= '0;
      end else if (lfsr_en) begin
        bit_idx_reg  <= bit_idx_reg + 1'b1;
      end

      if (state_reg == ST_DONE) begin
        ok_reg <= (crc == exp_reg);
      end
    end
  end

  crc_24_ble_lfsr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (lfsr_load),
    .init_i  (init_i),
    .en_i    (lfsr_en),
    .data_i  (byte_reg[bit_idx_reg]),
    .crc_o   (crc)
  );

  assign s_bus.s_ready = (state_reg == ST_ACCEPT);
  assign busy_o        = (state_reg != ST_IDLE);
  assign done_o        = (state_reg == ST_DONE);
  assign crc_o         = crc;
  assign byte_cnt_o    = byte_cnt_reg;

  // In DONE the compare is shown directly so it lines up with done_o; the
  // registered copy taken on leaving DONE holds it through IDLE.
  assign crc_ok_o = (state_reg == ST_DONE) ? (crc == exp_reg) : ok_reg;

endmodule : crc_24_ble_ctrl

// File: tb/tb_crc_24_ble_ctrl.sv
module tb_crc_24_ble_ctrl;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i;
  logic [23:0] init_i;
  logic [23:0] exp_crc_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic [23:0] crc_o;
  logic        crc_ok_o;
  logic [15:0] byte_cnt_o;

  crc_24_ble_ctrl_if bus ();

  crc_24_ble_ctrl dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .init_i     (init_i),
    .exp_crc_i  (exp_crc_i),
    .abort_i    (abort_i),
    .s_bus      (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .crc_o      (crc_o),
    .crc_ok_o   (crc_ok_o),
    .byte_cnt_o (byte_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  logic [7:0] pkt_q[$];
  int         hs_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Reference: CRC defined bit by bit, LSB of each byte first.
  function automatic logic [23:0] crc_bits(input logic [23:0] c, input logic [7:0] b, input int n);
    int r;
    r = int'(c);
    for (int i = 0; i < n; i++) begin
      int d;
      int top;
      d   = (int'(b) >> i) & 1;
      top = (r >> 23) & 1;
      r   = (r << 1) & 32'hFFFFFF;
      if (top != d) r = r ^ 32'h00065B;
    end
    return r[23:0];
  endfunction

  function automatic logic [23:0] ref_crc(input logic [23:0] seed);
    logic [23:0] c;
    c = seed;
    foreach (pkt_q[i]) c = crc_bits(c, pkt_q[i], 8);
    return c;
  endfunction

  task automatic do_start(input logic [23:0] init, input logic [23:0] exp);
    start_i   = 1'b1;
    init_i    = init;
    exp_crc_i = exp;
    tick();
    start_i   = 1'b0;
    init_i    = $urandom;
    exp_crc_i = $urandom;
  endtask

  // Sends pkt_q; max_gap = 0 keeps s_valid high across bytes.
  task automatic send_bytes(input int max_gap);
    hs_q.delete();
    for (int i = 0; i < pkt_q.size(); i++) begin
      int gap;
      int waited;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        bus.s_valid = 1'b0;
        repeat (gap) tick();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = pkt_q[i];
      bus.s_last  = (i == pkt_q.size() - 1);
      waited = 0;
      while (!bus.s_ready && waited < 40) begin
        tick();
        waited++;
      end
      if (!bus.s_ready) begin
        check("hs_timeout", 64'd0, 64'd1);
        break;
      end
      tick();
      hs_q.push_back(cyc);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Ticks until done_o; returns the number of edges after the last handshake.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_o && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_pkt(input string tag, input logic [23:0] init,
                         input logic [23:0] exp, input int max_gap);
    int          lat;
    logic [23:0] want;
    want = ref_crc(init);
    do_start(init, exp);
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    send_bytes(max_gap);
    wait_done(lat);
    check({tag, "_done_lat"}, 64'(lat), 64'd8);
    check({tag, "_crc"}, 64'(crc_o), 64'(want));
    check({tag, "_ok"}, 64'(crc_ok_o), 64'(want == exp));
    check({tag, "_cnt"}, 64'(byte_cnt_o), 64'(pkt_q.size()));
    $display("pkt %s len %0d init %h crc %h exp %h ok %0d", tag, pkt_q.size(), init, crc_o, exp, crc_ok_o);
    tick();
    check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    check({tag, "_idle"}, 64'(busy_o), 64'd0);
    check({tag, "_ok_hold"}, 64'(crc_ok_o), 64'(want == exp));
    check({tag, "_crc_hold"}, 64'(crc_o), 64'(want));
  endtask

  initial begin
    rst_n_i     = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    init_i      = '0;
    exp_crc_i   = '0;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b0;
    @(negedge clk_i);
    tick();
    tick();

    // Reset state
    check("rst_crc",   64'(crc_o), 64'd0);
    check("rst_ready", 64'(bus.s_ready), 64'd0);
    check("rst_busy",  64'(busy_o), 64'd0);
    check("rst_done",  64'(done_o), 64'd0);
    check("rst_ok",    64'(crc_ok_o), 64'd0);
    check("rst_cnt",   64'(byte_cnt_o), 64'd0);
    rst_n_i     = 1'b1;
    bus.s_valid = 1'b0;
    tick();

    // Single byte 0x01 and 0x80 with matching / mismatching expectation
    pkt_q = {8'h01};
    run_pkt("b01", 24'h000000, 24'h000000, 0);
    check("b01_const", 64'(crc_o), 64'h032D80);
    pkt_q = {8'h80};
    run_pkt("b80_ok", 24'h000000, 24'h00065B, 0);
    check("b80_const", 64'(crc_o), 64'h00065B);
    check("b80_okbit", 64'(crc_ok_o), 64'd1);
    run_pkt("b80_bad", 24'h000000, 24'h00065A, 0);
    check("b80_badbit", 64'(crc_ok_o), 64'd0);

    // Two bytes back to back, valid held high
    pkt_q = {8'h01, 8'h00};
    run_pkt("two", 24'h000000, 24'h2D8AED, 0);
    check("two_const", 64'(crc_o), 64'h2D8AED);
    if (hs_q.size() == 2) check("two_spacing", 64'(hs_q[1] - hs_q[0]), 64'd9);
    else check("two_hs_count", 64'(hs_q.size()), 64'd2);

    // Abort mid-SHIFT
    do_start(24'hABCDEF, 24'h0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    tick();
    bus.s_valid = 1'b0;
    repeat (3) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    check("abort_crc",  64'(crc_o), 64'(crc_bits(24'hABCDEF, 8'h00, 3)));
    begin
      int saw_ready;
      int saw_done;
      saw_ready = 0;
      saw_done  = 0;
      bus.s_valid = 1'b1;
      repeat (12) begin
        if (bus.s_ready) saw_ready++;
        if (done_o) saw_done++;
        tick();
      end
      bus.s_valid = 1'b0;
      check("abort_no_ready", 64'(saw_ready), 64'd0);
      check("abort_no_done",  64'(saw_done), 64'd0);
    end

    // start + abort together in IDLE stays IDLE
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start_abort_idle", 64'(busy_o), 64'd0);

    // start/valid during SHIFT ignored, then reset mid-SHIFT
    do_start(24'h123456, 24'h0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    bus.s_last  = 1'b0;
    tick();
    start_i = 1'b1;
    repeat (3) tick();
    start_i     = 1'b0;
    bus.s_valid = 1'b0;
    check("ign_cnt",   64'(byte_cnt_o), 64'd1);
    check("ign_busy",  64'(busy_o), 64'd1);
    check("ign_ready", 64'(bus.s_ready), 64'd0);
    check("ign_crc",   64'(crc_o), 64'(crc_bits(24'h123456, 8'h5A, 3)));
    rst_n_i = 1'b0;
    tick();
    check("mrst_crc",   64'(crc_o), 64'd0);
    check("mrst_busy",  64'(busy_o), 64'd0);
    check("mrst_ready", 64'(bus.s_ready), 64'd0);
    check("mrst_done",  64'(done_o), 64'd0);
    check("mrst_cnt",   64'(byte_cnt_o), 64'd0);
    rst_n_i = 1'b1;
    tick();
    check("mrst_idle", 64'(busy_o), 64'd0);

    // Random packets
    for (int p = 0; p < 25; p++) begin
      int          len;
      logic [23:0] init;
      logic [23:0] exp;
      len  = int'($urandom_range(64, 1));
      init = 24'($urandom);
      pkt_q.delete();
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
      exp = ref_crc(init);
      if ($urandom_range(1, 0) == 0) exp = exp ^ 24'(1 << $urandom_range(23, 0));
      run_pkt($sformatf("rnd%0d", p), init, exp, int'($urandom_range(3, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_crc_24_ble_ctrl

// File: doc/crc_24_ble_ctrl.md
Name: crc_24_ble_ctrl

Overview:
Byte-level sequencer for a bit-serial 24-bit BLE CRC LFSR. It does the following:
- accepts a packet as a byte stream over a valid/ready handshake;
- seeds the LFSR with a per-packet init value;
- shifts each byte LSB-first, one bit per clock;
- reports the final CRC and a pass/fail compare against an expected CRC.

It sits between the link-layer packet buffer and the TX CRC append / RX CRC check logic.

Parameters:
WIDTH, 24, CRC register width.
POLY, 24'h00065B, feedback taps (x^24 implicit). Default is the BLE polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1.
CNT_W, 16, width of the byte counter.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  reset; synchronous, active-low
start_i  in  1  begin packet; sampled only in IDLE
init_i  in  WIDTH  LFSR seed, sampled with start_i
exp_crc_i  in  WIDTH  expected CRC, sampled with start_i
abort_i  in  1  abandon current packet, any state
s_data_i  in  8  packet byte
s_valid_i  in  1  byte valid
s_last_i  in  1  marks final byte of packet
s_ready_o  out  1  byte accepted when s_valid_i && s_ready_o
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse, CRC final
crc_o  out  WIDTH  LFSR contents (final value valid from done_o onward)
crc_ok_o  out  1  crc_o == captured exp_crc, valid with done_o, held until next start
byte_cnt_o  out  CNT_W  bytes accepted in current packet

Behaviour:
- Reset (rst_n_i low at clock edge): state=IDLE; crc=0, s_ready_o=0, busy_o=0, done_o=0, crc_ok_o=0, byte_cnt_o=0, bit counter=0. Reset overrides every other input.
- LFSR step, Galois form, per bit d:
  - fb = crc[WIDTH-1] ^ d
  - crc <= {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)
- States:
  - IDLE: on start_i: crc<=init_i, capture exp_crc_i, byte_cnt<=0, crc_ok_o<=0, go ACCEPT.
  - ACCEPT: s_ready_o=1 (combinational from state only, not from s_valid_i). On handshake: capture s_data_i and s_last_i, byte_cnt+=1, bit_idx<=0, go SHIFT.
  - SHIFT: one LFSR step per cycle with d=byte[bit_idx], bit 0 first; 8 cycles. After the step with bit_idx=7: if captured last, go DONE, else go ACCEPT.
  - DONE: done_o=1 for this single cycle; crc_ok_o registered as (crc==exp_crc); go IDLE.
- Timing and throughput:
  - Handshake at edge t; SHIFT steps at edges t+1..t+8; ACCEPT again from t+8, so the next handshake is at t+9 earliest. Throughput is 1 byte per 9 cycles.
  - After the last byte, crc_o is final after edge t+8; done_o is high in the following cycle.
- Holding: crc_o, crc_ok_o and byte_cnt_o hold their values in IDLE until the next start_i.
- Ignored inputs:
  - start_i outside IDLE is ignored.
  - s_valid_i outside ACCEPT is ignored; bytes are not consumed.
  - s_last_i is meaningful only at handshake.
- abort_i: in any non-IDLE state, go IDLE next cycle, no done_o, crc_o holds its partial value; abort_i has priority over the handshake in the same cycle. In IDLE, abort_i has priority over start_i (start is dropped).
- start_i and abort_i together in IDLE: remain IDLE.
- byte_cnt_o wraps modulo 2^CNT_W; no error is flagged.
- Minimum packet is 1 byte; a zero-length packet is the caller's job, since crc=init_i.

Decomposition:
- Package crc_24_ble_pkg: BLE_POLY=24'h00065B, BLE_ADV_INIT=24'h555555, CRC_W=24, state enumeration (IDLE, ACCEPT, SHIFT, DONE).
- Sub-module crc_24_ble_lfsr: WIDTH/POLY-parameterised serial LFSR with ports clk_i, rst_n_i, load_i, init_i, en_i, data_i, crc_o. load_i has priority over en_i.
- The controller holds the FSM, byte shift register, 3-bit bit index, byte counter and compare.

Test Plan:
- init=0, single byte 0x01 (last) -> done_o 9 cycles after the handshake edge, crc_o=24'h032D80, byte_cnt_o=1.
- init=0, single byte 0x80 -> crc_o=24'h00065B. With exp_crc=24'h00065B -> crc_ok_o=1; with exp_crc=24'h00065A -> crc_ok_o=0.
- init=0, bytes 0x01,0x00 (last on second), s_valid_i held high throughout -> handshakes exactly 9 cycles apart, crc_o=24'h2D8AED, byte_cnt_o=2.
- init=24'hABCDEF, byte 0x00 then abort_i mid-SHIFT -> no done_o, busy_o low next cycle, s_ready_o never high until next start_i.
- start_i asserted during SHIFT, and s_valid_i during SHIFT -> both ignored, only one byte counted. Then rst_n_i low mid-SHIFT -> all outputs 0 on the next edge, state IDLE.
- Random packets 1-64 bytes, random init, random s_valid_i gaps -> crc_o matches a reference model of the same LFSR step, for every packet.
